// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: valid tracking, stall/flush, forwarding, memory wait.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN = 1'b0, ST_MWAIT = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic               r_vd, r_ve, r_vm, r_vw;
  logic [WCNT_W-1:0]  r_wait_cnt, w_wait_next;
  logic               r_mem_err;
  logic               w_memstall, w_redirect, w_loaduse;

  assign w_memstall = r_vm & MemAccessM & ~mem_ready;
  assign w_redirect = r_ve & PCSrcE;
  assign w_loaduse  = r_ve & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                      ((RdE == Rs1D) | (RdE == Rs2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    // Memory wait freezes everything upstream of W; branch/load-use wait until it clears.
    if (w_memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_redirect) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_loaduse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (r_vm & RegWriteM & (RdM != 5'd0) & (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (r_vw & RegWriteW & (RdW != 5'd0) & (RdW == Rs1E)) ForwardAE = 2'b01;
    if (r_vm & RegWriteM & (RdM != 5'd0) & (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (r_vw & RegWriteW & (RdW != 5'd0) & (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_memstall) w_state_next = ST_MWAIT;
      ST_MWAIT: if (mem_ready)  w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
    // Counts consecutive stalled cycles, saturating at the timeout value.
    w_wait_next = '0;
    if (w_memstall)
      w_wait_next = (r_wait_cnt == TIMEOUT_VAL) ? r_wait_cnt : r_wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
      r_vd       <= 1'b0;
      r_ve       <= 1'b0;
      r_vm       <= 1'b0;
      r_vw       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == TIMEOUT_VAL) r_mem_err <= 1'b1;
      r_vd <= StallD ? r_vd : ~FlushD;
      r_ve <= StallE ? r_ve : (FlushE ? 1'b0 : r_vd);
      r_vm <= StallM ? r_vm : r_ve;
      r_vw <= FlushW ? 1'b0 : r_vm;
    end
  end

  assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushE) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, forwarding, redirect, memory stall and timeout.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready;
  logic [1:0] ResultSrcE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] ctl;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
    MemAccessM = 0; mem_ready = 1;
  endtask

  // Advance one edge; inputs change 2 time units after it, checks happen 2 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset_fill();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({ctl, ForwardAE, ForwardBE, mem_err} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got ctl=%b fa=%b fb=%b err=%b, expected all 0", ctl, ForwardAE, ForwardBE, mem_err);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt);
    end
    $display("reset: ctl=%b", ctl);
  endtask

  task automatic test_reset_mid_wait();
    do_reset_fill();
    MemAccessM = 1; mem_ready = 0;
    step(); step();
    n_cmp++;
    if (ctl !== 7'b1111001) begin
      n_err++;
      $display("FAIL midwait_stall: got %b expected 1111001", ctl);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ctl, ForwardAE, ForwardBE, mem_err} !== 12'd0) begin
      n_err++;
      $display("FAIL midwait_reset_outputs: got ctl=%b, expected 0", ctl);
    end
    n_cmp++;
    if (dut.r_state !== 1'b0) begin
      n_err++;
      $display("FAIL midwait_reset_state: got %b expected 0 (RUN)", dut.r_state);
    end
    MemAccessM = 0; mem_ready = 1;
    #1 rst_n = 1'b1;
    step();
    n_cmp++;
    if ({dut.r_vd, dut.r_ve} !== 2'b10) begin
      n_err++;
      $display("FAIL release_valid: got vD,vE=%b expected 10", {dut.r_vd, dut.r_ve});
    end
    $display("reset mid-wait: state=%b vD=%b", dut.r_state, dut.r_vd);
  endtask

  task automatic test_load_use();
    do_reset_fill();
    ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    #2;
    n_cmp++;
    if (ctl !== 7'b1100010) begin
      n_err++;
      $display("FAIL loaduse_stall: got %b expected 1100010", ctl);
    end
    step();
    RdM = 5'd5; RegWriteM = 1;
    #2;
    n_cmp++;
    if (ctl !== 7'b0000000) begin
      n_err++;
      $display("FAIL loaduse_selfclear: got %b expected 0000000", ctl);
    end
    step();
    ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;
    Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1;
    #2;
    n_cmp++;
    if (ForwardAE !== 2'b01) begin
      n_err++;
      $display("FAIL loaduse_fwd_w: got %b expected 01", ForwardAE);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {CNT_W'(PERF), CNT_W'(PERF)}) begin
      n_err++;
      $display("FAIL loaduse_counters: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, PERF, PERF);
    end
    $display("load-use: fwdA=%b stall_cnt=%0d", ForwardAE, stall_cnt);
  endtask

  task automatic test_forwarding();
    do_reset_fill();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1; RegWriteW = 1; Rs1E = 5'd7; Rs2E = 5'd7;
    #2;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      n_err++;
      $display("FAIL fwd_m_priority: got %b/%b expected 10/10", ForwardAE, ForwardBE);
    end
    RegWriteM = 0;
    #2;
    n_cmp++;
    if (ForwardAE !== 2'b01) begin
      n_err++;
      $display("FAIL fwd_w_only: got %b expected 01", ForwardAE);
    end
    RegWriteM = 1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    #2;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      n_err++;
      $display("FAIL fwd_x0: got %b/%b expected 00/00", ForwardAE, ForwardBE);
    end
    RdM = 5'd9; RdW = 5'd3; Rs1E = 5'd9; Rs2E = 5'd3;
    #2;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1001) begin
      n_err++;
      $display("FAIL fwd_split: got %b/%b expected 10/01", ForwardAE, ForwardBE);
    end
    $display("forwarding: fwdA=%b fwdB=%b", ForwardAE, ForwardBE);
  endtask

  task automatic test_redirect();
    do_reset_fill();
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    #2;
    n_cmp++;
    if (ctl !== 7'b0000110) begin
      n_err++;
      $display("FAIL redirect_over_loaduse: got %b expected 0000110", ctl);
    end
    step();
    clear_inputs();
    step();
    n_cmp++;
    if ({dut.r_vd, dut.r_ve} !== 2'b10) begin
      n_err++;
      $display("FAIL redirect_valid: got vD,vE=%b expected 10", {dut.r_vd, dut.r_ve});
    end
    n_cmp++;
    if (flush_cnt !== CNT_W'(PERF)) begin
      n_err++;
      $display("FAIL redirect_flush_cnt: got %0d expected %0d", flush_cnt, PERF);
    end
    $display("redirect: vD=%b vE=%b", dut.r_vd, dut.r_ve);
  endtask

  task automatic test_memstall();
    do_reset_fill();
    MemAccessM = 1; mem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (ctl !== 7'b1111001) begin
        n_err++;
        $display("FAIL memstall_cycle%0d: got %b expected 1111001", i, ctl);
      end
      step();
    end
    mem_ready = 1;
    #2;
    n_cmp++;
    if (ctl !== 7'b0000110) begin
      n_err++;
      $display("FAIL memstall_release_redirect: got %b expected 0000110", ctl);
    end
    step();
    clear_inputs();
    #2;
    n_cmp++;
    if ({stall_cnt, flush_cnt, mem_err} !== {CNT_W'(3 * PERF), CNT_W'(PERF), 1'b0}) begin
      n_err++;
      $display("FAIL memstall_counters: got %0d/%0d err=%b expected %0d/%0d err=0",
               stall_cnt, flush_cnt, mem_err, 3 * PERF, PERF);
    end
    $display("memstall: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
  endtask

  task automatic test_timeout();
    do_reset_fill();
    MemAccessM = 1; mem_ready = 0;
    repeat (MEM_TIMEOUT - 1) step();
    n_cmp++;
    if (mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got %b expected 0", mem_err);
    end
    step();
    n_cmp++;
    if ({mem_err, StallM} !== 2'b11) begin
      n_err++;
      $display("FAIL timeout_set: got err,StallM=%b expected 11", {mem_err, StallM});
    end
    mem_ready = 1;
    step();
    MemAccessM = 0;
    step();
    n_cmp++;
    if ({mem_err, StallF} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_sticky: got err,StallF=%b expected 10", {mem_err, StallF});
    end
    $display("timeout: mem_err=%b", mem_err);
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_load_use();
    test_forwarding();
    test_redirect();
    test_memstall();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-sequencing controller for the five-stage RISC-V pipeline. Tracks per-stage valid bits, produces stall/flush enables for the F, D, E, M and W pipeline registers, selects E-stage operand forwarding, and holds the pipeline while the data memory is not ready. Sits beside the datapath. Its stall/flush outputs drive the enable and clear of the decode→execute control register and its siblings.

## Interface
Parameters:
- MEM_TIMEOUT, 64: number of consecutive data-memory wait cycles after which `mem_err` is raised (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  sources and destination in E.
- RdM, RdW  in  5  destinations in M, W.
- RegWriteM, RegWriteW  in  1  register-write control in M, W.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- PCSrcE  in  1  branch taken or jump in E.
- MemAccessM  in  1  M-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble into the register.
- ForwardAE, ForwardBE  out  2  00 register file, 10 from M, 01 from W.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Configuration).

## Operation
- Valid bits vD, vE, vM, vW are reset to 0. Each clock:
  - vD ← StallD ? vD : !FlushD.
  - vE ← StallE ? vE : (FlushE ? 0 : vD).
  - vM ← StallM ? vM : vE.
  - vW ← FlushW ? 0 : vM.
- Memory FSM states:
  - RUN → MWAIT when vM & MemAccessM & !mem_ready.
  - MWAIT → RUN when mem_ready.
  - A wait counter clears in RUN and increments in MWAIT, saturating.
  - `mem_err` sets when the counter reaches MEM_TIMEOUT. It clears only on reset, and the stall persists.
- memstall = vM & MemAccessM & !mem_ready, combinational in both states.
- Priority, highest first:
  1. memstall: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. Branch and load-use decisions are deferred.
  2. Redirect (vE & PCSrcE): FlushD=1, FlushE=1, no stalls. This overrides load-use.
  3. Load-use (vE & ResultSrcE==01 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D)): StallF=StallD=1, FlushE=1.
  4. Otherwise all outputs are 0.
- Forwarding, for A (Rs1E) and likewise B (Rs2E):
  - 10 if vM & RegWriteM & RdM≠0 & RdM==Rs1E.
  - Else 01 if vW & RegWriteW & RdW==Rs1E & RdW≠0.
  - Else 00. M has priority over W.
  - Forwarding is independent of stalls.
- Register x0 never causes forwarding or a load-use stall.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state, with zero-cycle latency. Valid bits and the FSM update on the next edge.
- All outputs are 0 on reset: valid bits 0, FSM in RUN, counters 0, mem_err 0.
- Asserting rst_n low mid-wait returns the FSM to RUN immediately and drops every stall output asynchronously.
- A load-use stall lasts exactly one cycle. The bubble enters E, vE=0 the next cycle, so the condition self-clears.
- memstall lasts until the cycle in which mem_ready=1. On that cycle no memory stall is asserted and the M instruction advances.
- A redirect coincident with memstall is acted on in the first cycle after memstall clears, because the E instruction is held.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle StallF=1.
  - flush_cnt increments every cycle FlushE=1.
  - Both wrap at 2^CNT_W and reset to 0.
- Undefined: the counter registers are not built and both outputs are tied to 0.

## Test plan
- Reset pulse mid-MWAIT: all outputs read 0 while rst_n=0; FSM returns to RUN; vD=1 one cycle after release.
- Load at E writing x5, D reads x5: StallF=StallD=FlushE=1 for exactly one cycle; next cycle ForwardAE=01 (from W) once the load reaches W.
- RdM=RdW=x7, both writing, Rs1E=x7 → ForwardAE=10. Same with RdM=x0 and RdW=x0 → ForwardAE=00.
- PCSrcE=1 together with a load-use hazard: FlushD=FlushE=1, StallF=0; after two cycles vD=1, vE=0.
- Memory stall and timeout:
  - MemAccessM=1 with mem_ready low for 3 cycles: StallF..M=1, FlushW=1 for 3 cycles, then release. stall_cnt=3 with HAZARD_PERF_CNT_EN.
  - mem_ready held low for MEM_TIMEOUT cycles: mem_err rises and stays 1 after mem_ready returns.
